// File: rtl/timer_pkg.sv
// Shared definitions for the APB register interface of the 8-bit timer.
// Optional feature macro: TIMER_APB_IRQ_EN (adds TIER at 0x4 and the irq output).
package timer_pkg;

    // Register addresses (paddr[2:0])
    localparam logic [2:0] ADDR_TDR  = 3'h0;
    localparam logic [2:0] ADDR_TCR  = 3'h1;
    localparam logic [2:0] ADDR_TSR  = 3'h2;
    localparam logic [2:0] ADDR_TCNT = 3'h3;
    localparam logic [2:0] ADDR_TIER = 3'h4;

    // Highest decoded address; everything above it is an error
`ifdef TIMER_APB_IRQ_EN
    localparam logic [2:0] ADDR_LAST = ADDR_TIER;
`else
    localparam logic [2:0] ADDR_LAST = ADDR_TCNT;
`endif

    // Register select uses the address itself; this code marks "no register"
    localparam logic [2:0] SEL_NONE  = 3'h7;

    // TCR bit positions
    localparam int LOAD_BIT = 7;
    localparam int UPDN_BIT = 5;
    localparam int EN_BIT   = 4;

    // TSR / TIER bit positions
    localparam int OVF_BIT  = 0;
    localparam int UDF_BIT  = 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    // Map an address to a register select, or SEL_NONE when out of range
    function automatic logic [2:0] reg_sel(input logic [2:0] a, input logic hi_zero);
        return (hi_zero && (a <= ADDR_LAST)) ? a : SEL_NONE;
    endfunction

endpackage

// File: rtl/timer_apb_fsm.sv
// APB3 handshake: tracks setup/access phases, counts wait states and
// produces pready, the commit strobe, the register select and the error flag.
// SETUP means "setup phase seen, this cycle must be the first access cycle";
// ACCESS covers the remaining wait-state cycles.
module timer_apb_fsm import timer_pkg::*; #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_psel,
    input  logic              i_penable,
    input  logic              i_pwrite,
    input  logic [ADDR_W-1:0] i_paddr,
    output logic              o_pready,
    output logic              o_commit,
    output logic              o_err,
    output logic [2:0]        o_sel
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    apb_state_t r_state, w_state_nxt;
    logic [2:0] r_wait, w_wait_nxt;
    logic       w_hi_zero;

    generate
        if (ADDR_W > 3) begin : g_hi
            assign w_hi_zero = ~|i_paddr[ADDR_W-1:3];
        end else begin : g_nohi
            assign w_hi_zero = 1'b1;
        end
    endgenerate

    assign o_sel    = reg_sel(i_paddr[2:0], w_hi_zero);
    assign o_err    = (o_sel == SEL_NONE) || (i_pwrite && (o_sel == ADDR_TCNT));
    assign o_commit = o_pready && !o_err;

    // State and wait-counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_wait  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // Next-state, wait counting and pready generation
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        o_pready    = 1'b0;
        case (r_state)
            IDLE: begin
                w_wait_nxt = 3'd0;
                if (i_psel && !i_penable) w_state_nxt = SETUP;
            end
            SETUP, ACCESS: begin
                if (!(i_psel && i_penable)) begin
                    // protocol violation: drop the transfer silently
                    w_state_nxt = IDLE;
                    w_wait_nxt  = 3'd0;
                end else if (r_wait == WS) begin
                    o_pready    = 1'b1;
                    w_state_nxt = IDLE;
                    w_wait_nxt  = 3'd0;
                end else begin
                    w_state_nxt = ACCESS;
                    w_wait_nxt  = r_wait + 3'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_wait_nxt  = 3'd0;
            end
        endcase
    end

endmodule

// File: rtl/timer_apb_regif.sv
// APB3 register interface for the 8-bit timer counter: TDR, TCR, TSR (W1C),
// TCNT (RO). Optional macro TIMER_APB_IRQ_EN adds TIER at 0x4 and irq.
module timer_apb_regif import timer_pkg::*; #(
    parameter int         ADDR_W      = 8,
    parameter int         WAIT_STATES = 0,
    parameter logic [7:0] TDR_RST     = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [7:0]        pwdata,
    output logic [7:0]        prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [7:0]        start_counter,
    output logic              up_down,
    output logic              enable,
    output logic              load,
    output logic              clr_overflow,
    output logic              clr_underflow,
    input  logic [7:0]        cnt_value,
    input  logic              overflow,
    input  logic              underflow
`ifdef TIMER_APB_IRQ_EN
   ,output logic              irq
`endif
);

    logic       w_pready, w_commit, w_err, w_wr;
    logic [2:0] w_sel;
    logic [7:0] w_rdata;
    logic [7:0] r_tdr;
    logic       r_updn, r_en, r_load, r_clr_ovf, r_clr_udf;

    timer_apb_fsm #(.ADDR_W(ADDR_W), .WAIT_STATES(WAIT_STATES)) u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_psel    (psel),
        .i_penable (penable),
        .i_pwrite  (pwrite),
        .i_paddr   (paddr),
        .o_pready  (w_pready),
        .o_commit  (w_commit),
        .o_err     (w_err),
        .o_sel     (w_sel)
    );

    assign w_wr = w_commit && pwrite;

    // TDR/TCR storage and one-cycle load/clear pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tdr     <= TDR_RST;
            r_updn    <= 1'b0;
            r_en      <= 1'b0;
            r_load    <= 1'b0;
            r_clr_ovf <= 1'b0;
            r_clr_udf <= 1'b0;
        end else begin
            r_load    <= 1'b0;
            r_clr_ovf <= 1'b0;
            r_clr_udf <= 1'b0;
            if (w_wr && (w_sel == ADDR_TDR)) r_tdr <= pwdata;
            if (w_wr && (w_sel == ADDR_TCR)) begin
                r_updn <= pwdata[UPDN_BIT];
                r_en   <= pwdata[EN_BIT];
                r_load <= pwdata[LOAD_BIT];
            end
            if (w_wr && (w_sel == ADDR_TSR)) begin
                r_clr_ovf <= pwdata[OVF_BIT];
                r_clr_udf <= pwdata[UDF_BIT];
            end
        end
    end

`ifdef TIMER_APB_IRQ_EN
    logic r_ovie, r_udie, r_irq;

    // Interrupt enables and registered interrupt line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovie <= 1'b0;
            r_udie <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr && (w_sel == ADDR_TIER)) begin
                r_ovie <= pwdata[OVF_BIT];
                r_udie <= pwdata[UDF_BIT];
            end
            r_irq <= (overflow && r_ovie) || (underflow && r_udie);
        end
    end

    assign irq = r_irq;
`endif

    // Read mux; status and count are sampled live in the pready cycle
    always_comb begin
        w_rdata = 8'h00;
        case (w_sel)
            ADDR_TDR:  w_rdata = r_tdr;
            ADDR_TCR: begin
                w_rdata[UPDN_BIT] = r_updn;
                w_rdata[EN_BIT]   = r_en;
            end
            ADDR_TSR: begin
                w_rdata[OVF_BIT] = overflow;
                w_rdata[UDF_BIT] = underflow;
            end
            ADDR_TCNT: w_rdata = cnt_value;
`ifdef TIMER_APB_IRQ_EN
            ADDR_TIER: begin
                w_rdata[OVF_BIT] = r_ovie;
                w_rdata[UDF_BIT] = r_udie;
            end
`endif
            default:   w_rdata = 8'h00;
        endcase
    end

    assign pready        = w_pready;
    assign pslverr       = w_pready && w_err;
    assign prdata        = (w_pready && !pwrite && !w_err) ? w_rdata : 8'h00;
    assign start_counter = r_tdr;
    assign up_down       = r_updn;
    assign enable        = r_en;
    assign load          = r_load;
    assign clr_overflow  = r_clr_ovf;
    assign clr_underflow = r_clr_udf;

endmodule
